// File: rtl/alu_issue_wb.sv
// Operand-issue / writeback stage for the 8-bit ALU: serial IDLE -> EXEC -> WB per instruction.
// Optional ALU_ISSUE_R0_ZERO_EN makes r0 read as zero and ignore writes.
module alu_issue_wb #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3,
  localparam int unsigned IW = 5 + 3 * AW + DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [DW-1:0] aye,
  output logic [DW-1:0] bee,
  output logic [DW-1:0] lit,
  output logic [4:0]    calu,
  input  logic [DW-1:0] cee,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          ill_op,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e          state_q, state_d;
  logic [4:0]      op_in;
  logic [AW-1:0]   rd_in, ra_in, rb_in;
  logic [DW-1:0]   lit_in;
  logic [4:0]      op_q;
  logic [AW-1:0]   rd_q;
  logic [DW-1:0]   aye_q, bee_q, lit_q, res_q;
  logic            ill_q;
  logic [DW-1:0]   rf [2**AW];
  logic            legal, accept, rf_we;

  assign op_in  = instr[IW-1 -: 5];
  assign rd_in  = instr[IW-6 -: AW];
  assign ra_in  = instr[IW-6-AW -: AW];
  assign rb_in  = instr[IW-6-2*AW -: AW];
  assign lit_in = instr[DW-1:0];

  assign legal       = op_in inside {[5'h01:5'h08], [5'h11:5'h13], [5'h15:5'h17]};
  // Ready depends on state only; reset forces it low while asserted.
  assign instr_ready = (state_q == StIdle) && !rst;
  assign accept      = instr_valid && instr_ready;

`ifdef ALU_ISSUE_R0_ZERO_EN
  assign rf_we = (state_q == StWb) && (rd_q != '0);
`else
  assign rf_we = (state_q == StWb);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && legal) state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      rd_q    <= '0;
      aye_q   <= '0;
      bee_q   <= '0;
      lit_q   <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
      rf      <= '{default: '0};
    end else begin
      state_q <= state_d;
      ill_q   <= accept && !legal;
      if (accept && legal) begin
        op_q  <= op_in;
        rd_q  <= rd_in;
        aye_q <= rf[ra_in];
        bee_q <= rf[rb_in];
        lit_q <= lit_in;
      end
      if (state_q == StExec) res_q <= cee;
      if (rf_we) rf[rd_q] <= res_q;
    end
  end

  assign aye      = aye_q;
  assign bee      = bee_q;
  assign lit      = lit_q;
  assign calu     = (state_q == StExec) ? op_q : 5'h00;
  assign wb_valid = (state_q == StWb);
  assign wb_addr  = rd_q;
  assign wb_data  = res_q;
  assign ill_op   = ill_q;
  assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_wb.sv
// Randomized bench for alu_issue_wb: timeline-based reference model plus directed literal checks.
module tb_alu_issue_wb;

  logic        clk, rst;
  logic [21:0] instr;
  logic        instr_valid, instr_ready;
  logic [7:0]  aye, bee, lit, cee, wb_data, dbg_data;
  logic [4:0]  calu;
  logic        wb_valid, ill_op;
  logic [2:0]  wb_addr, dbg_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit dbg_rand = 0;

  alu_issue_wb dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .aye(aye), .bee(bee), .lit(lit), .calu(calu),
    .cee(cee), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ill_op(ill_op), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Stand-in ALU: any stateless function of the operands will do.
  function automatic logic [7:0] alu_ref(input logic [4:0] op, input logic [7:0] a, b, l);
    logic [15:0] p;
    p = a * b;
    case (op)
      5'h01: return a + b;
      5'h02: return a - b;
      5'h03: return p[7:0];
      5'h04: return a & b;
      5'h05: return a | b;
      5'h06: return a ^ b;
      5'h07: return ~a;
      5'h08: return ~(a + b);
      5'h11: return l;
      5'h12: return a + l;
      5'h13: return a ^ l;
      5'h15: return {a[6:0], 1'b0};
      5'h16: return {1'b0, a[7:1]};
      5'h17: return b;
      default: return 8'hEE;
    endcase
  endfunction

  assign cee = alu_ref(calu, aye, bee, lit);

  function automatic bit is_legal(input logic [4:0] op);
    int v;
    v = int'(op);
    return (v >= 1 && v <= 8) || (v >= 17 && v <= 19) || (v >= 21 && v <= 23);
  endfunction

  function automatic logic [21:0] mk(input logic [4:0] op, input logic [2:0] rd, ra, rb,
                                     input logic [7:0] l);
    return {op, rd, ra, rb, l};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: edge numbers of the last accepted legal/illegal instruction.
  logic [4:0] i_op;
  logic [2:0] i_rd, i_ra, i_rb;
  logic [7:0] i_lit;
  assign {i_op, i_rd, i_ra, i_rb, i_lit} = instr;

  logic [7:0] m_rf [8];
  logic [7:0] m_aye, m_bee, m_lit, m_res;
  logic [4:0] m_op;
  logic [2:0] m_rd;
  int acc_edge = -10;
  int ill_edge = -10;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rf     <= '{default: '0};
      m_aye    <= '0;
      m_bee    <= '0;
      m_lit    <= '0;
      m_res    <= '0;
      m_op     <= '0;
      m_rd     <= '0;
      acc_edge <= -10;
      ill_edge <= -10;
    end else begin
      if (cyc + 1 == acc_edge + 2) begin
`ifdef ALU_ISSUE_R0_ZERO_EN
        if (m_rd != 3'd0) m_rf[m_rd] <= m_res;
`else
        m_rf[m_rd] <= m_res;
`endif
      end
      if (instr_valid && (cyc + 1 >= acc_edge + 3)) begin
        if (is_legal(i_op)) begin
          m_aye    <= m_rf[i_ra];
          m_bee    <= m_rf[i_rb];
          m_lit    <= i_lit;
          m_op     <= i_op;
          m_rd     <= i_rd;
          m_res    <= alu_ref(i_op, m_rf[i_ra], m_rf[i_rb], i_lit);
          acc_edge <= cyc + 1;
        end else begin
          ill_edge <= cyc + 1;
        end
      end
    end
  end

  // Compare process, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", instr_ready, 0);
      chk("rst_calu", calu, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_ill_op", ill_op, 0);
      chk("rst_aye", aye, 0);
      chk("rst_bee", bee, 0);
      chk("rst_lit", lit, 0);
      chk("rst_wb_addr", wb_addr, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_dbg", dbg_data, 0);
    end else begin
      chk("ready", instr_ready, cyc >= acc_edge + 2);
      chk("calu", calu, (cyc == acc_edge) ? m_op : 5'h00);
      chk("wb_valid", wb_valid, cyc == acc_edge + 1);
      if (cyc == acc_edge + 1) begin
        chk("wb_addr", wb_addr, m_rd);
        chk("wb_data", wb_data, m_res);
      end
      chk("ill_op", ill_op, cyc == ill_edge);
      chk("aye", aye, m_aye);
      chk("bee", bee, m_bee);
      chk("lit", lit, m_lit);
      chk("dbg_data", dbg_data, m_rf[dbg_addr]);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      instr = 22'($urandom);
      if (dbg_rand) dbg_addr = 3'($urandom);
    end
  endtask

  // Returns 1ns after the accepting edge; acc holds that edge number.
  task automatic issue(input logic [21:0] w, output int acc);
    bit done;
    done = 0;
    acc = -1;
    instr = w;
    instr_valid = 1;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        done = 1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: instruction %0h not accepted", w);
    end
    instr_valid = 0;
    instr = 22'($urandom);
    if (dbg_rand) dbg_addr = 3'($urandom);
  endtask

  logic [4:0] legal_tab [14] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08,
                                 5'h11, 5'h12, 5'h13, 5'h15, 5'h16, 5'h17};

  initial begin
    int t1, t2, t3;
    logic [4:0] op;
    rst = 0; instr_valid = 0; instr = '0; dbg_addr = '0;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1 chk("rst_dbg_all", dbg_data, 0);
    end
    chk("rst_ready_low", instr_ready, 0);
    @(posedge clk); #1 rst = 0;
    #1 chk("ready_after_rst", instr_ready, 1);

    // Load r1/r2 then add.
    issue(mk(5'h11, 3'd1, 3'd0, 3'd0, 8'h05), t1);
    issue(mk(5'h11, 3'd2, 3'd0, 3'd0, 8'h03), t2);
    issue(mk(5'h01, 3'd3, 3'd1, 3'd2, 8'h00), t3);
    chk("spacing_load", t2 - t1, 3);
    chk("spacing_add", t3 - t2, 3);
    chk("add_calu", calu, 5'h01);
    chk("add_aye", aye, 8'h05);
    chk("add_bee", bee, 8'h03);
    @(posedge clk); #1;
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_addr", wb_addr, 3);
    chk("add_wb_data", wb_data, 8'h08);
    @(posedge clk); #1;
    dbg_addr = 3;
    #1 chk("add_rf3", dbg_data, 8'h08);
    chk("add_ready_back", instr_ready, 1);

    // Multiply truncation.
    issue(mk(5'h11, 3'd1, 3'd0, 3'd0, 8'h20), t1);
    issue(mk(5'h11, 3'd2, 3'd0, 3'd0, 8'h10), t1);
    issue(mk(5'h03, 3'd4, 3'd1, 3'd2, 8'h00), t1);
    chk("mul_calu", calu, 5'h03);
    @(posedge clk); #1;
    chk("mul_wb_addr", wb_addr, 4);
    chk("mul_wb_data", wb_data, 8'h00);
    @(posedge clk); #1;

    // Illegal opcodes back to back.
    issue(mk(5'h14, 3'd3, 3'd1, 3'd2, 8'h55), t1);
    chk("ill_pulse", ill_op, 1);
    chk("ill_ready", instr_ready, 1);
    chk("ill_no_wb", wb_valid, 0);
    issue(mk(5'h1F, 3'd3, 3'd1, 3'd2, 8'h66), t2);
    chk("ill_spacing", t2 - t1, 1);
    @(posedge clk); #1;
    chk("ill_pulse_end", ill_op, 0);
    dbg_addr = 3;
    #1 chk("ill_rf3_kept", dbg_data, 8'h08);

    // Reset during EXEC drops the instruction.
    issue(mk(5'h11, 3'd5, 3'd0, 3'd0, 8'hAA), t1);
    rst = 1;
    #1 chk("midrst_calu", calu, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    @(posedge clk); #1 chk("midrst_wb_valid2", wb_valid, 0);
    @(posedge clk); #1 rst = 0;
    dbg_addr = 5;
    #1 chk("midrst_rf5", dbg_data, 0);

`ifdef ALU_ISSUE_R0_ZERO_EN
    issue(mk(5'h11, 3'd0, 3'd0, 3'd0, 8'h7F), t1);
    @(posedge clk); #1;
    chk("r0_wb_valid", wb_valid, 1);
    chk("r0_wb_data", wb_data, 8'h7F);
    @(posedge clk); #1;
    dbg_addr = 0;
    #1 chk("r0_stays_zero", dbg_data, 0);
`endif

    // Randomized traffic with occasional resets.
    dbg_rand = 1;
    for (int n = 0; n < 400; n++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) op = 5'($urandom);
      else op = legal_tab[$urandom_range(0, 13)];
      issue(mk(op, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom)), t1);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1;
        idle(2);
        rst = 0;
      end
    end
    idle(6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
